// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchronized RX_IN, oversampled start/data/parity/stop recovery.
// Optional build macro RX_MAJORITY_VOTE_EN selects 2-of-3 majority sampling around mid-bit.
module uart_rx_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;

  logic [PRESCALE_W-1:0] half_pt, samp_pt, stop_exit, last_edge;
  logic                  bit_val, at_samp, at_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s      <= rx_meta_q;
    end
  end

  assign half_pt = prescale_q >> 1;

`ifdef RX_MAJORITY_VOTE_EN
  // hist_q[0] holds rx_s from the previous cycle, hist_q[1] from two cycles ago.
  logic [1:0] hist_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign samp_pt = half_pt + PRESCALE_W'(1);
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign samp_pt = half_pt;
  assign bit_val = rx_s;
`endif

  assign stop_exit = samp_pt + PRESCALE_W'(1);
  assign last_edge = prescale_q - PRESCALE_W'(1);
  assign at_samp   = (edge_cnt_q == samp_pt);
  assign at_last   = (edge_cnt_q == last_edge);

  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = edge_cnt_q + PRESCALE_W'(1);
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    prescale_d     = prescale_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    par_err_d      = par_err_q;
    stop_err_d     = stop_err_q;
    p_data_d       = p_data_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        edge_cnt_d = '0;
        if (!rx_s) begin
          state_d    = StStart;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      StStart: begin
        if (at_samp && bit_val) begin
          state_d    = StIdle;
          edge_cnt_d = '0;
        end else if (at_last) begin
          state_d    = StData;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      StData: begin
        if (at_samp) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        end
        if (at_last) begin
          edge_cnt_d = '0;
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (at_samp) begin
          par_err_d = (bit_val != ((^shift_q) ^ par_typ_q));
        end
        if (at_last) begin
          edge_cnt_d = '0;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (at_samp) begin
          stop_err_d = ~bit_val;
        end
        // Leave before the bit ends so a back-to-back start edge is not missed.
        if (edge_cnt_q == stop_exit) begin
          state_d        = StIdle;
          edge_cnt_d     = '0;
          parity_error_d = par_err_q;
          stop_error_d   = stop_err_q;
          if (!par_err_q && !stop_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= StIdle;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      prescale_q     <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      prescale_q     <= prescale_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      par_err_q      <= par_err_d;
      stop_err_q     <= stop_err_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = data_valid_q;
  assign Parity_Error = parity_error_q;
  assign Stop_Error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected pulses, a monitor checks them.
module tb_uart_rx_core;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_core #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .Parity_Error(Parity_Error),
    .Stop_Error  (Stop_Error)
  );

  always #5 CLK = ~CLK;

  // Monitor: any output pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RST && (Data_Valid || Parity_Error || Stop_Error)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b data=%02h, required no pulse",
                 Data_Valid, Parity_Error, Stop_Error, P_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({Data_Valid, Parity_Error, Stop_Error, P_DATA} != e) begin
          failures++;
          $display("FAIL frame_result: got dv=%0b pe=%0b se=%0b data=%02h, required dv=%0b pe=%0b se=%0b data=%02h",
                   Data_Valid, Parity_Error, Stop_Error, P_DATA, e.dv, e.pe, e.se, e.data);
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %02h, required %02h", name, got, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_val({name, "_pdata"}, P_DATA, 8'h00);
    check_val({name, "_flags"}, {5'b0, Data_Valid, Parity_Error, Stop_Error}, 8'h00);
  endtask

  // spike_bit >= 0 inverts that data bit for one cycle at the DUT's centre sample.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input int spike_bit,
                            input logic edv, input logic epe, input logic ese,
                            input logic [7:0] edata);
    exp_t e;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    e = '{dv: edv, pe: epe, se: ese, data: edata};
    exp_q.push_back(e);
    RX_IN = 1'b0;
    hold(p);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      if (i == spike_bit) begin
        hold(p / 2 + 1);
        RX_IN = ~d[i];
        hold(1);
        RX_IN = d[i];
        hold(p - p / 2 - 2);
      end else begin
        hold(p);
      end
    end
    if (pen) begin
      RX_IN = pbit;
      hold(p);
    end
    RX_IN = sbit;
    hold(p);
    RX_IN = 1'b1;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      hold(1);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    hold(20);
  endtask

  initial begin
    RST      = 1'b1;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    hold(3);
    check_outputs_zero("reset_state");
    RST = 1'b0;
    hold(10);

    // 0xA5, Prescale 8, no parity.
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'hA5);
    drain("a5");

    // 0x3C even parity: bit 0 good, bit 1 error with P_DATA held.
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h3C);
    drain("3c_par_ok");
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'h3C);
    drain("3c_par_bad");

    // Odd parity: 0x07 has three ones, so odd parity bit is 0.
    send_frame(8'h07, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h07);
    drain("07_odd");

    // Stop error then a good frame, Prescale 32.
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h07);
    drain("81_stop");
    send_frame(8'h7E, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h7E);
    drain("7e");

    // Parity and stop errors together.
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1, 8'h7E);
    drain("both_err");

    // Start glitch: two low cycles must produce no pulse.
    Prescale = 6'd16;
    RX_IN = 1'b0;
    hold(2);
    RX_IN = 1'b1;
    hold(60);
    check_val("glitch_pdata", P_DATA, 8'h7E);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h55);
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'hAA);
    drain("b2b");

    // Reset during data bit 4 of an aborted frame.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    hold(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = i[0];
      hold(8);
    end
    RX_IN = 1'b1;
    hold(4);
    RST = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    hold(3);
    RST = 1'b0;
    hold(20);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h0F);
    drain("0f");

`ifdef RX_MAJORITY_VOTE_EN
    // One-cycle spike at the centre of bit 2 is outvoted.
    send_frame(8'h04, 16, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h04);
    drain("spike");
`endif

    check_val("final_pdata", P_DATA, 8'h0F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive path for the UART block: oversampled serial-to-parallel receiver, the counterpart of the TX serializer/FSM.
- Frame format: start bit, 8 data bits LSB-first, optional parity, one stop bit.
- Recovers bit timing from RX_IN using a per-bit edge counter at Prescale × baud.
- Presents the byte on P_DATA with a one-cycle Data_Valid pulse for the system-side controller.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of Prescale input and edge counter

Ports:
CLK  input  1  system clock, oversample rate = Prescale × baud
RST  input  1  asynchronous active-high reset
RX_IN  input  1  serial line, idle high, asynchronous to CLK
Prescale  input  PRESCALE_W  oversample ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WIDTH  last received byte, held until next good frame
Data_Valid  output  1  one-cycle pulse, good frame
Parity_Error  output  1  one-cycle pulse, parity mismatch
Stop_Error  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-high.
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - Synchronizer flops reset to 1.
- RX_IN path: 2-FF synchronizer; all timing below refers to the synchronized signal rx_s.
- Prescale and PAR_EN/PAR_TYP are captured on the IDLE→START transition; changes mid-frame are ignored.
- Timing counters:
  - edge_cnt counts 0..Prescale-1 within each bit, then wraps to 0 and bit_cnt increments.
  - Sample point S = Prescale/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s = 0, go to START with edge_cnt = 0.
- START:
  - Sample at edge_cnt = S.
  - Sample 1 (glitch): go to IDLE immediately; no output pulse.
  - Otherwise, at edge_cnt = Prescale-1, go to DATA.
- DATA:
  - Sample each bit at S and shift it in LSB-first.
  - After bit DATA_WIDTH-1 completes: go to PARITY if PAR_EN, else STOP.
- PARITY:
  - Sample at S.
  - Error when sampled bit ≠ (^data) XOR PAR_TYP.
- STOP:
  - Sample at S; sample 0 is a stop error.
  - At edge_cnt = S+1, resolve the frame and go to IDLE. This early exit allows the next start edge to be caught in the second half of the stop bit.
- Frame resolution, in the cycle after the STOP sample:
  - No errors: P_DATA updates to the received byte and Data_Valid = 1 for exactly one cycle.
  - Any error: Data_Valid stays 0 and P_DATA keeps its old value. Parity_Error and/or Stop_Error pulse one cycle; both may assert together.
- Back-to-back frames: a start bit detected right after returning to IDLE is accepted with no lost frame.
- Reset mid-frame: abort immediately; no pulses; P_DATA = 0.
- Line stuck low: after a stop error, IDLE re-enters START immediately. Each further bit period of low yields another frame attempt; no lockup.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined:
  - Each bit value is the 2-of-3 majority of samples at edge_cnt = S-1, S, S+1.
  - The decision is available at S+1; start-glitch reject and the STOP exit move one cycle later (exit at S+2).
- Undefined: single sample at S, as above.
- Data_Valid/P_DATA format is identical in both builds.

Test Plan:
- Prescale = 8, PAR_EN = 0, send 0xA5 with a correct stop bit -> P_DATA = 0xA5, single-cycle Data_Valid, no error pulses.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity bit 0 -> Data_Valid, P_DATA = 0x3C. Repeat with parity bit 1 -> Parity_Error pulse, no Data_Valid, P_DATA still 0x3C.
- Prescale = 32, send 0x81 with stop bit 0 -> Stop_Error pulse only. Then send 0x7E with a valid frame -> Data_Valid, P_DATA = 0x7E.
- Drive a 2-cycle low glitch on an idle line, Prescale = 16 -> returns to IDLE; no pulses; P_DATA unchanged.
- Send 0x55 then 0xAA back-to-back with no idle gap, Prescale = 8 -> two Data_Valid pulses with P_DATA 0x55 then 0xAA.
- Assert RST during data bit 4 -> all outputs 0 immediately. The next full frame 0x0F is received correctly. With RX_MAJORITY_VOTE_EN, a 1-cycle inverted spike at S on bit 2 leaves the byte uncorrupted.
